mult_div_sequencer: RTL and testbench



---
 rtl/mult_div_sequencer.sv | 99 +++++++++
 tb/tb_mult_div_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - multi-cycle unsigned MULTU/DIVU unit, one result bit per clock
module mult_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic [WIDTH-1:0] b_q;
    // acc is the product upper half (MULTU) or partial remainder (DIVU);
    // lower is the multiplier shift register (MULTU) or quotient (DIVU).
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] lower;

    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] lower_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic             last;
    logic             accept;

    assign last   = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign accept = start && ((state == S_IDLE) || (state == S_FIN));

    always_comb begin
        sum      = acc + (lower[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        r_sh     = {acc[WIDTH-1:0], lower[WIDTH-1]};
        acc_nx   = {1'b0, sum[WIDTH:1]};
        lower_nx = {sum[0], lower[WIDTH-1:1]};
        if (op_q) begin
            if (r_sh >= {1'b0, b_q}) begin
                acc_nx   = r_sh - {1'b0, b_q};
                lower_nx = {lower[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx   = r_sh;
                lower_nx = {lower[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= 1'b0;
            b_q         <= '0;
            acc         <= '0;
            lower       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            done        <= last;
            div_by_zero <= last && op_q && (b_q == '0);
            if (accept) begin
                state <= S_RUN;
                busy  <= 1'b1;
                cnt   <= '0;
                op_q  <= op;
                b_q   <= B;
                acc   <= '0;
                lower <= A;
            end else if (state == S_RUN) begin
                acc   <= acc_nx;
                lower <= lower_nx;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    HI    <= acc_nx[WIDTH-1:0];
                    LO    <= lower_nx;
                    state <= S_FIN;
                    busy  <= 1'b0;
                end
            end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb/tb_mult_div_sequencer.sv - self-checking bench for mult_div_sequencer
module tb_mult_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;
    exp_t sb[$];

    mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge; drives start through one rising edge and pushes the expected result.
    task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        if (o == 1'b0) begin
            p = {32'd0, a} * {32'd0, b};
            e.hi = p[63:32]; e.lo = p[31:0]; e.dbz = 1'b0;
        end else if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
            e.hi = a % b; e.lo = a / b; e.dbz = 1'b0;
        end
        sb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns edges from the accepting edge to done (-1 on timeout); optionally pokes start/A/B mid-run.
    task automatic wait_done(input int poke_at, output int edges, output int busy_cnt,
                             output int early_dbz);
        edges = -1; busy_cnt = (busy === 1'b1) ? 1 : 0; early_dbz = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == poke_at) begin
                start = 1'b1; op = 1'b1; A = 32'd50; B = 32'd5;
            end else if (n == poke_at + 1) begin
                start = 1'b0; A = $urandom; B = $urandom;
            end
            if (done === 1'b1) begin
                edges = n + 1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            if (div_by_zero !== 1'b0) early_dbz++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, div_by_zero, HI, LO} !== 67'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b dbz=%b HI=%h LO=%h want all 0",
                     busy, done, div_by_zero, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, HI, LO} !== 66'd0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b HI=%h LO=%h want 0", busy, done, HI, LO);
        end
    endtask

    task automatic check_result(input string name, input int edges, input int busy_cnt,
                                input int early_dbz);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (edges !== 33) begin
            failures++;
            $display("FAIL %s_latency got %0d edges want 33", name, edges);
        end
        checks++;
        if (busy_cnt !== 32) begin
            failures++;
            $display("FAIL %s_busy_cycles got %0d want 32", name, busy_cnt);
        end
        checks++;
        if (HI !== e.hi || LO !== e.lo) begin
            failures++;
            $display("FAIL %s_result got HI=%h LO=%h want HI=%h LO=%h", name, HI, LO, e.hi, e.lo);
        end
        checks++;
        if (div_by_zero !== e.dbz || early_dbz !== 0) begin
            failures++;
            $display("FAIL %s_dbz got %b (early %0d) want %b", name, div_by_zero, early_dbz, e.dbz);
        end
    endtask

    task automatic run_one(input string name, input logic o, input logic [31:0] a,
                           input logic [31:0] b, input int poke_at);
        int edges, busy_cnt, early;
        launch(o, a, b);
        wait_done(poke_at, edges, busy_cnt, early);
        check_result(name, edges, busy_cnt, early);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_done got done=%b dbz=%b busy=%b want 0 0 0",
                     name, done, div_by_zero, busy);
        end
    endtask

    task automatic test_multu;
        run_one("mul_7x9", 1'b0, 32'd7, 32'd9, 0);
        run_one("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_one("mul_rand", 1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 0);
    endtask

    task automatic test_divu;
        run_one("div_100_7", 1'b1, 32'd100, 32'd7, 0);
        run_one("div_by_zero", 1'b1, 32'd5, 32'd0, 0);
        run_one("div_big", 1'b1, 32'hFFFF_FFFF, 32'd3, 0);
    endtask

    task automatic test_start_ignored;
        run_one("ignore_start", 1'b0, 32'd3, 32'd4, 10);
    endtask

    task automatic test_reset_midrun;
        int edges, busy_cnt, early;
        launch(1'b1, 32'd1000, 32'd3);
        void'(sb.pop_front());
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero, HI, LO} !== 67'd0) begin
            failures++;
            $display("FAIL reset_midrun got busy=%b done=%b dbz=%b HI=%h LO=%h want all 0",
                     busy, done, div_by_zero, HI, LO);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_done(0, edges, busy_cnt, early);
        checks++;
        if (edges !== -1 || busy_cnt !== 0) begin
            failures++;
            $display("FAIL reset_no_done got done_edges=%0d busy_cycles=%0d want -1 0", edges, busy_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int edges, busy_cnt, early;
        launch(1'b0, 32'd6, 32'd7);
        wait_done(0, edges, busy_cnt, early);
        check_result("b2b_mul", edges, busy_cnt, early);
        launch(1'b1, 32'd9, 32'd2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b want 1", busy);
        end
        wait_done(0, edges, busy_cnt, early);
        check_result("b2b_div", edges, busy_cnt, early);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
